// File: rtl/act_stream_tx.sv
// Activation stream transmitter: requantizes signed accumulator words to DATA_WIDTH-bit activations
// (bias, rounding shift, ReLU/saturation) and tags each with a sequential address and a last flag.
module act_stream_tx #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ACC_WIDTH     = 32,
  parameter int unsigned ADDRESS_WIDTH = 10,
  parameter int unsigned SHIFT_WIDTH   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start_i,
  input  logic [ADDRESS_WIDTH:0]   cfg_map_size_i,
  input  logic [ACC_WIDTH-1:0]     cfg_bias_i,
  input  logic [SHIFT_WIDTH-1:0]   cfg_shift_i,
  input  logic                     cfg_relu_en_i,
  input  logic                     acc_valid_i,
  input  logic [ACC_WIDTH-1:0]     acc_data_i,
  output logic                     acc_ready_o,
  output logic                     act_valid_o,
  output logic                     act_last_o,
  output logic [DATA_WIDTH-1:0]    act_result_o,
  output logic [ADDRESS_WIDTH-1:0] act_result_address_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int unsigned SUM_W = ACC_WIDTH + 1;
  localparam int unsigned RND_W = ACC_WIDTH + 2;
  localparam int unsigned CNT_W = ADDRESS_WIDTH + 1;

  localparam logic signed [RND_W-1:0] UMAX = RND_W'((1 << DATA_WIDTH) - 1);
  localparam logic signed [RND_W-1:0] SMAX = RND_W'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [RND_W-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        size_m1_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [ACC_WIDTH-1:0]    bias_q;
  logic [SHIFT_WIDTH-1:0]  shift_q;
  logic                    relu_q;

  logic                    v1_q;
  logic                    last1_q;
  logic [SUM_W-1:0]        sum_q;
  logic [ADDRESS_WIDTH-1:0] addr1_q;

  logic                    start_c;
  logic                    accept_c;
  logic                    last_acc_c;
  logic signed [RND_W-1:0] rnd_c;
  logic signed [RND_W-1:0] ext_c;
  logic signed [RND_W-1:0] r_c;
  logic [DATA_WIDTH-1:0]   res_c;

  assign start_c    = (state_q == IDLE) & cfg_start_i & (cfg_map_size_i != '0);
  assign accept_c   = (state_q == RUN) & acc_valid_i;
  assign last_acc_c = accept_c & (cnt_q == size_m1_q);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_c) state_d = RUN;
      RUN:     if (last_acc_c) state_d = FLUSH;
      FLUSH:   if (act_last_o) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Round-half-up shift at ACC_WIDTH+2, then clamp to the selected output range
  always_comb begin
    rnd_c = '0;
    if (shift_q != '0) rnd_c = RND_W'(1) << (shift_q - SHIFT_WIDTH'(1));
    ext_c = $signed({sum_q[SUM_W-1], sum_q}) + rnd_c;
    r_c   = ext_c >>> shift_q;
    res_c = r_c[DATA_WIDTH-1:0];
    if (relu_q) begin
      if (r_c[RND_W-1])   res_c = '0;
      else if (r_c > UMAX) res_c = UMAX[DATA_WIDTH-1:0];
    end else begin
      if (r_c > SMAX)      res_c = SMAX[DATA_WIDTH-1:0];
      else if (r_c < SMIN) res_c = SMIN[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q              <= IDLE;
      acc_ready_o          <= 1'b0;
      busy_o               <= 1'b0;
      done_o               <= 1'b0;
      size_m1_q            <= '0;
      cnt_q                <= '0;
      bias_q               <= '0;
      shift_q              <= '0;
      relu_q               <= 1'b0;
      v1_q                 <= 1'b0;
      last1_q              <= 1'b0;
      sum_q                <= '0;
      addr1_q              <= '0;
      act_valid_o          <= 1'b0;
      act_last_o           <= 1'b0;
      act_result_o         <= '0;
      act_result_address_o <= '0;
    end else begin
      state_q     <= state_d;
      acc_ready_o <= (state_d == RUN);
      busy_o      <= (state_d != IDLE);
      done_o      <= (state_d == DONE);

      if (start_c) begin
        size_m1_q <= cfg_map_size_i - CNT_W'(1);
        bias_q    <= cfg_bias_i;
        shift_q   <= cfg_shift_i;
        relu_q    <= cfg_relu_en_i;
        cnt_q     <= '0;
      end else if (accept_c) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      // Stage 1: bias add, widened so it cannot overflow
      v1_q <= accept_c;
      if (accept_c) begin
        sum_q   <= $signed({acc_data_i[ACC_WIDTH-1], acc_data_i}) +
                   $signed({bias_q[ACC_WIDTH-1], bias_q});
        addr1_q <= cnt_q[ADDRESS_WIDTH-1:0];
        last1_q <= (cnt_q == size_m1_q);
      end

      // Stage 2: requantized output, zeroed when not valid
      act_valid_o          <= v1_q;
      act_last_o           <= v1_q & last1_q;
      act_result_o         <= v1_q ? res_c : '0;
      act_result_address_o <= v1_q ? addr1_q : '0;
    end
  end

endmodule

// File: tb/tb_act_stream_tx.sv
// Directed bench for act_stream_tx: captures the activation stream at negedge and compares it
// against hand-computed vectors and, for the full-size map, a longint reference function.
module tb_act_stream_tx;

  logic        clk;
  logic        rst;
  logic        cfg_start_i;
  logic [10:0] cfg_map_size_i;
  logic [31:0] cfg_bias_i;
  logic [4:0]  cfg_shift_i;
  logic        cfg_relu_en_i;
  logic        acc_valid_i;
  logic [31:0] acc_data_i;
  logic        acc_ready_o;
  logic        act_valid_o;
  logic        act_last_o;
  logic [7:0]  act_result_o;
  logic [9:0]  act_result_address_o;
  logic        busy_o;
  logic        done_o;

  act_stream_tx dut (
    .clk                  (clk),
    .rst                  (rst),
    .cfg_start_i          (cfg_start_i),
    .cfg_map_size_i       (cfg_map_size_i),
    .cfg_bias_i           (cfg_bias_i),
    .cfg_shift_i          (cfg_shift_i),
    .cfg_relu_en_i        (cfg_relu_en_i),
    .acc_valid_i          (acc_valid_i),
    .acc_data_i           (acc_data_i),
    .acc_ready_o          (acc_ready_o),
    .act_valid_o          (act_valid_o),
    .act_last_o           (act_last_o),
    .act_result_o         (act_result_o),
    .act_result_address_o (act_result_address_o),
    .busy_o               (busy_o),
    .done_o               (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_cnt = 0;
  int done_cyc = 0;
  int last_cyc = 0;
  logic [7:0] cap_data[$];
  logic [9:0] cap_addr[$];
  logic       cap_last[$];
  int         cap_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output capture away from the active edge
  always @(negedge clk) begin
    if (act_valid_o) begin
      cap_data.push_back(act_result_o);
      cap_addr.push_back(act_result_address_o);
      cap_last.push_back(act_last_o);
      cap_cyc.push_back(cyc);
    end
    if (act_last_o) begin
      last_cnt++;
      last_cyc = cyc;
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    cap_data.delete();
    cap_addr.delete();
    cap_last.delete();
    cap_cyc.delete();
  endtask

  // Config is scrambled after the start cycle to prove it was latched
  task automatic start(input int size, input int bias, input int shift, input bit relu);
    cfg_map_size_i = 11'(size);
    cfg_bias_i     = 32'(bias);
    cfg_shift_i    = 5'(shift);
    cfg_relu_en_i  = relu;
    cfg_start_i    = 1'b1;
    tick();
    cfg_start_i    = 1'b0;
    cfg_map_size_i = '0;
    cfg_bias_i     = 32'h5A5A_A5A5;
    cfg_shift_i    = 5'd17;
    cfg_relu_en_i  = ~relu;
  endtask

  task automatic send(input logic [31:0] d);
    acc_valid_i = 1'b1;
    acc_data_i  = d;
    tick();
    acc_valid_i = 1'b0;
    acc_data_i  = 32'hDEAD_BEEF;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!done_o && k < budget) begin
      tick();
      k++;
    end
    check({tag, ".done_seen"}, 32'(done_o), 32'd1);
    tick();
  endtask

  task automatic check_map(input string tag, input int n, input logic [7:0] exp[$]);
    logic [31:0] g;
    check({tag, ".count"}, 32'(cap_data.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      g = (i < cap_data.size()) ? 32'(cap_data[i]) : 32'hFFFF_FFFF;
      check($sformatf("%s.data[%0d]", tag, i), g, 32'(exp[i]));
      g = (i < cap_addr.size()) ? 32'(cap_addr[i]) : 32'hFFFF_FFFF;
      check($sformatf("%s.addr[%0d]", tag, i), g, 32'(i));
      g = (i < cap_last.size()) ? 32'(cap_last[i]) : 32'hFFFF_FFFF;
      check($sformatf("%s.last[%0d]", tag, i), g, 32'(i == n - 1));
    end
  endtask

  function automatic logic [7:0] model(input longint acc, input longint bias, input int sh,
                                       input bit relu);
    longint s;
    s = acc + bias;
    if (sh > 0) s = s + (longint'(1) << (sh - 1));
    s = s >>> sh;
    if (relu) begin
      if (s < 0) s = 0;
      if (s > 255) s = 255;
    end else begin
      if (s > 127) s = 127;
      if (s < -128) s = -128;
    end
    return 8'(s);
  endfunction

  initial begin
    logic [7:0] exp[$];
    int c0;
    int d0;
    int l0;
    int v;

    rst = 1'b1;
    cfg_start_i = 1'b0;
    cfg_map_size_i = '0;
    cfg_bias_i = '0;
    cfg_shift_i = '0;
    cfg_relu_en_i = 1'b0;
    acc_valid_i = 1'b0;
    acc_data_i = '0;

    // T1 reset
    repeat (3) tick();
    check("t1.valid", 32'(act_valid_o), 32'd0);
    check("t1.last", 32'(act_last_o), 32'd0);
    check("t1.result", 32'(act_result_o), 32'd0);
    check("t1.addr", 32'(act_result_address_o), 32'd0);
    check("t1.ready", 32'(acc_ready_o), 32'd0);
    check("t1.busy", 32'(busy_o), 32'd0);
    check("t1.done", 32'(done_o), 32'd0);
    rst = 1'b0;
    tick();

    // T2 basic ReLU with saturation, latency and done timing
    clr();
    d0 = done_cnt;
    start(4, 0, 0, 1'b1);
    check("t2.ready", 32'(acc_ready_o), 32'd1);
    check("t2.busy", 32'(busy_o), 32'd1);
    c0 = cyc;
    send(32'd5);
    send(-32'sd3);
    send(32'd300);
    send(32'd255);
    wait_done("t2", 20);
    exp = '{8'd5, 8'd0, 8'd255, 8'd255};
    check_map("t2", 4, exp);
    check("t2.latency", 32'((cap_cyc.size() > 0) ? cap_cyc[0] - c0 : -1), 32'd2);
    check("t2.done_after_last", 32'(done_cyc - last_cyc), 32'd1);
    check("t2.done_count", 32'(done_cnt - d0), 32'd1);
    check("t2.idle_busy", 32'(busy_o), 32'd0);
    check("t2.idle_done", 32'(done_o), 32'd0);

    // T3 rounding, signed clamp; second run starts on the first idle cycle after done
    clr();
    start(3, 2, 2, 1'b0);
    send(32'd5);
    send(32'd6);
    send(-32'sd10);
    wait_done("t3a", 20);
    exp = '{8'h02, 8'h02, 8'hFE};
    check_map("t3a", 3, exp);
    clr();
    start(1, 2, 2, 1'b0);
    check("t3b.started", 32'(busy_o), 32'd1);
    send(32'd600);
    wait_done("t3b", 20);
    exp = '{8'h7F};
    check_map("t3b", 1, exp);

    // T4 idle drops, valid gaps, ignored restart while busy
    clr();
    d0 = done_cnt;
    acc_valid_i = 1'b1;
    acc_data_i = 32'd99;
    tick();
    tick();
    acc_valid_i = 1'b0;
    check("t4.idle_ready", 32'(acc_ready_o), 32'd0);
    start(3, 0, 0, 1'b1);
    send(32'd10);
    tick();
    cfg_start_i = 1'b1;
    cfg_map_size_i = 11'd5;
    tick();
    cfg_start_i = 1'b0;
    cfg_map_size_i = '0;
    send(32'd20);
    tick();
    send(32'd30);
    wait_done("t4", 20);
    exp = '{8'd10, 8'd20, 8'd30};
    check_map("t4", 3, exp);
    check("t4.done_count", 32'(done_cnt - d0), 32'd1);

    // T5 reset mid-run
    clr();
    d0 = done_cnt;
    l0 = last_cnt;
    start(8, 0, 0, 1'b1);
    send(32'd1);
    send(32'd2);
    send(32'd3);
    rst = 1'b1;
    tick();
    check("t5.valid_after_rst", 32'(act_valid_o), 32'd0);
    check("t5.busy_after_rst", 32'(busy_o), 32'd0);
    rst = 1'b0;
    repeat (4) tick();
    check("t5.count", 32'(cap_data.size()), 32'd2);
    check("t5.no_done", 32'(done_cnt - d0), 32'd0);
    check("t5.no_last", 32'(last_cnt - l0), 32'd0);
    clr();
    start(2, 0, 0, 1'b1);
    send(32'd7);
    send(32'd8);
    wait_done("t5r", 20);
    exp = '{8'd7, 8'd8};
    check_map("t5r", 2, exp);

    // T6 full-size map against the reference function
    clr();
    d0 = done_cnt;
    l0 = last_cnt;
    exp.delete();
    start(1024, 200, 3, 1'b0);
    for (int i = 0; i < 1024; i++) begin
      v = $signed($urandom) >>> 20;
      exp.push_back(model(longint'(v), 200, 3, 1'b0));
      if ($urandom_range(0, 7) == 0) tick();
      send(32'(v));
    end
    wait_done("t6", 40);
    check_map("t6", 1024, exp);
    check("t6.done_count", 32'(done_cnt - d0), 32'd1);
    check("t6.last_count", 32'(last_cnt - l0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
